// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed seven-segment display scanner.
// Shows one digit at a time for DWELL_CYCLES. Each dwell opens with a dark
// guard of BLANK_CYCLES, and brightness is set by a 4-bit PWM. The display
// inputs are captured once per frame, so a single frame never mixes old and
// new values. Leading zeros can be suppressed.
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int DWELL_CYCLES   = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit EN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_suppress,
    input  logic [3:0]              brightness,
    output logic [6:0]              seven_segment,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   enable,
    output logic                    frame_tick
);

    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [DW-1:0] BLANK_VAL  = DW'(BLANK_CYCLES);
    localparam logic [DW-1:0] DW_ONE     = DW'(1);
    localparam logic [IW-1:0] DIGIT_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [IW-1:0] IW_ONE     = IW'(1);

    localparam logic [NUM_DIGITS-1:0] ONE_N  = NUM_DIGITS'(1);
    localparam logic [6:0]            SEG_POL = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_POL  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] EN_POL  = EN_ACTIVE_LOW ? '1 : '0;

    logic [DW-1:0]           dwell_cnt;
    logic [IW-1:0]           digit_idx;
    logic [3:0]              pwm_cnt;
    logic [4*NUM_DIGITS-1:0] snap_value;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic                    snap_lz;

    logic                    dwell_last;
    logic                    digit_last;
    logic                    frame_end;
    logic [NUM_DIGITS-1:0]   supp;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_supp;
    logic                    lit;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    assign dwell_last = (dwell_cnt == DWELL_LAST);
    assign digit_last = (digit_idx == DIGIT_LAST);
    assign frame_end  = dwell_last && digit_last;

    // Dwell timer, digit pointer and free-running PWM phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            dwell_cnt <= '0;
            digit_idx <= '0;
            pwm_cnt   <= 4'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            if (dwell_last) begin
                dwell_cnt <= '0;
                digit_idx <= digit_last ? '0 : digit_idx + IW_ONE;
            end else begin
                dwell_cnt <= dwell_cnt + DW_ONE;
            end
        end
    end

    // Capture the display inputs at the last cycle of each frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_value <= '0;
            snap_dp    <= '0;
            snap_lz    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            if (frame_end) begin
                snap_value <= value;
                snap_dp    <= dp_in;
                snap_lz    <= lz_suppress;
            end
        end
    end

    // A digit is a leading zero when it and every digit above it are zero.
    // Digit 0 is never suppressed, so a zero value still shows one "0".
    always_comb begin
        logic run_zero;
        supp     = '0;
        run_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run_zero = run_zero && (snap_value[4*i +: 4] == 4'd0);
            supp[i]  = snap_lz && run_zero;
        end
    end

    // Select the snapshot fields for the digit currently being scanned.
    always_comb begin
        cur_nib  = 4'd0;
        cur_dp   = 1'b0;
        cur_supp = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IW'(i)) begin
                cur_nib  = snap_value[4*i +: 4];
                cur_dp   = snap_dp[i];
                cur_supp = supp[i];
            end
        end
    end

    assign lit = (dwell_cnt >= BLANK_VAL)
              && ((brightness == 4'hF) || (pwm_cnt < brightness))
              && !cur_supp;

    // Registered pin drive. At most one enable is active, and none during the guard.
    always_ff @(posedge clk) begin
        if (reset) begin
            seven_segment <= SEG_POL;
            dp            <= DP_POL;
            enable        <= EN_POL;
        end else if (lit) begin
            seven_segment <= hex_decode(cur_nib) ^ SEG_POL;
            dp            <= cur_dp ^ DP_POL;
            enable        <= (ONE_N << digit_idx) ^ EN_POL;
        end else begin
            seven_segment <= SEG_POL;
            dp            <= DP_POL;
            enable        <= EN_POL;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver. Three instances share one set of inputs:
//   a: 4 digits, active-low pins
//   b: 4 digits, active-high pins
//   c: a single digit with a long dwell
// A reference model predicts the pins from elapsed cycles since reset and
// from the per-frame input snapshots.
module tb_seg7_scan_driver;

    localparam int D4    = 8;
    localparam int N4    = 4;
    localparam int D1    = 34;
    localparam int BLANK = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        lz_suppress = 1'b0;
    logic [3:0]  brightness = 4'hF;

    logic [6:0] seg_a, seg_b, seg_c;
    logic       dp_a, dp_b, dp_c;
    logic [3:0] en_a, en_b;
    logic [0:0] en_c;
    logic       tick_a, tick_b, tick_c;

    int checks = 0;
    int errors = 0;
    int k = 0;
    int cur_k = -1;

    logic [15:0] sa_v;
    logic [3:0]  sa_dp;
    logic        sa_lz;
    logic [3:0]  sc_v;
    logic        sc_dp;
    logic        sc_lz;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] en;
        logic       tick;
    } exp_t;

    typedef struct {
        logic [15:0]     v;
        logic [3:0]      dpi;
        logic            lz;
        logic [3:0][6:0] seg;
        logic [3:0]      litm;
        logic [3:0]      dpx;
    } vec_t;

    logic [6:0] hex_seg [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    seg7_scan_driver #(.NUM_DIGITS(4), .DWELL_CYCLES(D4), .BLANK_CYCLES(BLANK),
                       .SEG_ACTIVE_LOW(1'b1), .EN_ACTIVE_LOW(1'b1)) u_a (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in),
        .lz_suppress(lz_suppress), .brightness(brightness),
        .seven_segment(seg_a), .dp(dp_a), .enable(en_a), .frame_tick(tick_a));

    seg7_scan_driver #(.NUM_DIGITS(4), .DWELL_CYCLES(D4), .BLANK_CYCLES(BLANK),
                       .SEG_ACTIVE_LOW(1'b0), .EN_ACTIVE_LOW(1'b0)) u_b (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in),
        .lz_suppress(lz_suppress), .brightness(brightness),
        .seven_segment(seg_b), .dp(dp_b), .enable(en_b), .frame_tick(tick_b));

    seg7_scan_driver #(.NUM_DIGITS(1), .DWELL_CYCLES(D1), .BLANK_CYCLES(BLANK),
                       .SEG_ACTIVE_LOW(1'b1), .EN_ACTIVE_LOW(1'b1)) u_c (
        .clk(clk), .reset(reset), .value(value[3:0]), .dp_in(dp_in[0:0]),
        .lz_suppress(lz_suppress), .brightness(brightness),
        .seven_segment(seg_c), .dp(dp_c), .enable(en_c), .frame_tick(tick_c));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, cur_k);
        end
    endtask

    // Active-high pin values expected after the edge that ends state k.
    function automatic exp_t model_out(input int kk, input int d, input int n,
                                       input logic [15:0] sv, input logic [3:0] sdp,
                                       input logic slz, input logic [3:0] br);
        exp_t e;
        int dig, dw, pwm;
        logic [3:0] nib;
        logic sup;
        e   = '0;
        dw  = kk % d;
        dig = (kk / d) % n;
        pwm = kk % 16;
        nib = 4'(sv >> (4 * dig));
        sup = slz && (dig != 0) && ((sv >> (4 * dig)) == 16'h0);
        e.tick = ((kk % (d * n)) == (d * n - 1));
        if (dw >= BLANK && (br == 4'hF || pwm < int'(br)) && !sup) begin
            e.seg = hex_seg[nib];
            e.dp  = sdp[dig];
            e.en  = 4'(1 << dig);
        end
        return e;
    endfunction

    // One clock: advance the model at the edge, then compare at the falling edge.
    task automatic step();
        exp_t ea, ec;
        logic [6:0] s7;
        logic [3:0] e4;
        logic       b1;
        @(posedge clk);
        if (reset) begin
            ea = '0; ec = '0;
            k = 0; cur_k = -1;
            sa_v = 16'h0; sa_dp = 4'h0; sa_lz = 1'b0;
            sc_v = 4'h0;  sc_dp = 1'b0; sc_lz = 1'b0;
        end else begin
            ea = model_out(k, D4, N4, sa_v, sa_dp, sa_lz, brightness);
            ec = model_out(k, D1, 1, {12'h000, sc_v}, {3'b000, sc_dp}, sc_lz, brightness);
            if (k % (D4 * N4) == D4 * N4 - 1) begin
                sa_v = value; sa_dp = dp_in; sa_lz = lz_suppress;
            end
            if (k % D1 == D1 - 1) begin
                sc_v = value[3:0]; sc_dp = dp_in[0]; sc_lz = lz_suppress;
            end
            cur_k = k;
            k++;
        end
        @(negedge clk);
        s7 = ~ea.seg; chk("a_seg", 32'(seg_a), 32'(s7));
        b1 = ~ea.dp;  chk("a_dp", 32'(dp_a), 32'(b1));
        e4 = ~ea.en;  chk("a_en", 32'(en_a), 32'(e4));
        chk("a_tick", 32'(tick_a), 32'(ea.tick));
        chk("b_seg", 32'(seg_b), 32'(ea.seg));
        chk("b_dp", 32'(dp_b), 32'(ea.dp));
        chk("b_en", 32'(en_b), 32'(ea.en));
        chk("b_tick", 32'(tick_b), 32'(ea.tick));
        s7 = ~ec.seg; chk("c_seg", 32'(seg_c), 32'(s7));
        b1 = ~ec.dp;  chk("c_dp", 32'(dp_c), 32'(b1));
        b1 = ~ec.en[0]; chk("c_en", 32'(en_c), 32'(b1));
        chk("c_tick", 32'(tick_c), 32'(ec.tick));
        e4 = ~en_a;
        chk("a_not_multihot", 32'($countones(e4) <= 1), 32'd1);
        chk("b_not_multihot", 32'($countones(en_b) <= 1), 32'd1);
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        vec_t tbl[7];
        int   dig, ticks, cnt, jj;
        logic [6:0] s7;
        logic [3:0] e4;
        logic       b1;
        int   exp_cnt[3];
        logic [3:0] br_tab[3];
        logic [15:0] mask;

        tbl[0] = '{16'h1234, 4'b0000, 1'b0,
                   {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}, 4'b1111, 4'b0000};
        tbl[1] = '{16'hABCD, 4'b0101, 1'b0,
                   {7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101}, 4'b1111, 4'b0101};
        tbl[2] = '{16'h0050, 4'b1111, 1'b1,
                   {7'b0000000, 7'b0000000, 7'b1011011, 7'b1111110}, 4'b0011, 4'b0011};
        tbl[3] = '{16'h0000, 4'b0001, 1'b1,
                   {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}, 4'b0001, 4'b0001};
        tbl[4] = '{16'h0000, 4'b0000, 1'b0,
                   {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}, 4'b1111, 4'b0000};
        tbl[5] = '{16'h0E08, 4'b1000, 1'b1,
                   {7'b0000000, 7'b1001111, 7'b1111110, 7'b1111111}, 4'b0111, 4'b0000};
        tbl[6] = '{16'hF960, 4'b1010, 1'b1,
                   {7'b1000111, 7'b1111011, 7'b1011111, 7'b1111110}, 4'b1111, 4'b1010};

        // Table vectors: frame 1 shows the zero snapshot, frame 2 the vector.
        for (int t = 0; t < 7; t++) begin
            value = tbl[t].v; dp_in = tbl[t].dpi; lz_suppress = tbl[t].lz; brightness = 4'hF;
            reset_pulse();
            for (int c = 0; c < 64; c++) begin
                step();
                if (cur_k >= 32 && cur_k % D4 == D4 - 1) begin
                    dig = (cur_k / D4) % N4;
                    if (tbl[t].litm[dig]) begin
                        s7 = ~tbl[t].seg[dig];
                        e4 = ~(4'b0001 << dig);
                        b1 = ~tbl[t].dpx[dig];
                    end else begin
                        s7 = 7'h7F; e4 = 4'hF; b1 = 1'b1;
                    end
                    chk($sformatf("tbl%0d_d%0d_seg", t, dig), 32'(seg_a), 32'(s7));
                    chk($sformatf("tbl%0d_d%0d_en", t, dig), 32'(en_a), 32'(e4));
                    chk($sformatf("tbl%0d_d%0d_dp", t, dig), 32'(dp_a), 32'(b1));
                end
            end
        end

        // Mid-frame input change must not tear the frame; one frame_tick per 32 cycles.
        value = 16'h1234; dp_in = 4'h0; lz_suppress = 1'b0; brightness = 4'hF;
        reset_pulse();
        ticks = 0;
        for (int c = 0; c < 72; c++) begin
            step();
            if (cur_k >= 32 && cur_k <= 63 && tick_a) ticks++;
            if (cur_k == 43) value = 16'hABCD;
            if (cur_k == 55) begin
                chk("tear_d2_seg", 32'(seg_a), 32'(7'b0010010));
                chk("tear_d2_en", 32'(en_a), 32'(4'b1011));
            end
            if (cur_k == 71) begin
                chk("next_frame_d0_seg", 32'(seg_a), 32'(7'b1000010));
                chk("next_frame_d0_en", 32'(en_a), 32'(4'b1110));
            end
        end
        chk("frame_tick_per_frame", 32'(ticks), 32'd1);

        // Reset mid-dwell on digit 2; scan restarts at digit 0 with a zero snapshot.
        value = 16'h1234;
        reset_pulse();
        for (int c = 0; c < 21; c++) step();
        reset = 1'b1;
        step();
        chk("rst_seg", 32'(seg_a), 32'(7'h7F));
        chk("rst_en", 32'(en_a), 32'(4'hF));
        chk("rst_dp", 32'(dp_a), 32'd1);
        chk("rst_tick", 32'(tick_a), 32'd0);
        chk("rst_b_en", 32'(en_b), 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 8; c++) step();
        chk("restart_d0_seg", 32'(seg_a), 32'(7'b0000001));
        chk("restart_d0_en", 32'(en_a), 32'(4'b1110));
        chk("restart_hi_seg", 32'(seg_b), 32'(7'b1111110));
        chk("restart_hi_en", 32'(en_b), 32'(4'b0001));

        // PWM duty on the single-digit instance: 32-cycle lit window per dwell.
        exp_cnt[0] = 8;  exp_cnt[1] = 0;    exp_cnt[2] = 32;
        br_tab[0]  = 4'd4; br_tab[1] = 4'd0; br_tab[2] = 4'd15;
        brightness = br_tab[0];
        value = 16'h0000; lz_suppress = 1'b0;
        reset_pulse();
        cnt = 0; jj = 0;
        for (int c = 0; c < 3 * D1; c++) begin
            step();
            if (cur_k % D1 >= BLANK && en_c == 1'b0) cnt++;
            if (cur_k % D1 == D1 - 1) begin
                chk($sformatf("pwm_duty_br%0d", br_tab[jj]), 32'(cnt), 32'(exp_cnt[jj]));
                cnt = 0;
                if (jj < 2) begin
                    jj++;
                    brightness = br_tab[jj];
                end
            end
        end

        // Randomised inputs, with occasional resets, against the model.
        brightness = 4'hF;
        reset_pulse();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) begin
                case ($urandom_range(4))
                    0: mask = 16'hFFFF;
                    1: mask = 16'h0FFF;
                    2: mask = 16'h00FF;
                    3: mask = 16'h000F;
                    default: mask = 16'h0000;
                endcase
                value = 16'($urandom) & mask;
                dp_in = 4'($urandom);
                lz_suppress = 1'($urandom);
            end
            if ($urandom_range(63) == 0) brightness = 4'($urandom);
            reset = ($urandom_range(499) == 0);
            step();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
